cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 121 ++++++++++++
 tb/tb_cache_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Blocking cache controller: write-through, no-write-allocate, with a multi-word
// line refill on a read miss and saturating hit/miss statistics.
module cache_controller #(
   parameter int BLOCK_WORDS = 4,
   parameter int CNT_W       = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           MemRead,
   input  logic                           MemWrite,
   input  logic                           Hit,
   input  logic                           mem_ready,
   output logic                           Stall,
   output logic                           mem_rd_req,
   output logic                           mem_wr_req,
   output logic [$clog2(BLOCK_WORDS)-1:0] word_cnt,
   output logic                           refill_we,
   output logic                           valid_set,
   output logic                           cache_wr_en,
   output logic [CNT_W-1:0]               hit_count,
   output logic [CNT_W-1:0]               miss_count
);

   localparam int WC_W = $clog2(BLOCK_WORDS);
   localparam logic [WC_W-1:0] LAST_WORD = WC_W'(BLOCK_WORDS - 1);

   typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, RD_DONE} state_t;

   state_t           state_q, state_d;
   logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
   logic             wr_hit_q, wr_hit_d;
   logic [CNT_W-1:0] hit_count_q, hit_count_d;
   logic [CNT_W-1:0] miss_count_q, miss_count_d;
   logic             count_hit, count_miss;

   // A store wins when both strobes are high; while reset is high every output stays low.
   always_comb begin
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      wr_hit_d    = wr_hit_q;
      count_hit   = 1'b0;
      count_miss  = 1'b0;
      Stall       = 1'b0;
      mem_rd_req  = 1'b0;
      mem_wr_req  = 1'b0;
      refill_we   = 1'b0;
      valid_set   = 1'b0;
      cache_wr_en = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (MemWrite) begin
                  Stall      = 1'b1;
                  wr_hit_d   = Hit;
                  count_hit  = Hit;
                  count_miss = ~Hit;
                  state_d    = WR_THRU;
               end else if (MemRead) begin
                  if (Hit) begin
                     count_hit = 1'b1;
                  end else begin
                     Stall      = 1'b1;
                     count_miss = 1'b1;
                     word_cnt_d = '0;
                     state_d    = RD_MISS;
                  end
               end
            end
            RD_MISS: begin
               Stall      = 1'b1;
               mem_rd_req = 1'b1;
               if (mem_ready) begin
                  refill_we = 1'b1;
                  if (word_cnt_q == LAST_WORD) begin
                     valid_set  = 1'b1;
                     word_cnt_d = '0;
                     state_d    = RD_DONE;
                  end else begin
                     word_cnt_d = word_cnt_q + WC_W'(1);
                  end
               end
            end
            WR_THRU: begin
               mem_wr_req = 1'b1;
               Stall      = ~mem_ready;
               if (mem_ready) begin
                  cache_wr_en = wr_hit_q;
                  state_d     = IDLE;
               end
            end
            RD_DONE: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      // Statistics stick at all-ones instead of wrapping.
      hit_count_d  = (count_hit && hit_count_q != '1) ? hit_count_q + CNT_W'(1) : hit_count_q;
      miss_count_d = (count_miss && miss_count_q != '1) ? miss_count_q + CNT_W'(1) : miss_count_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         word_cnt_q   <= '0;
         wr_hit_q     <= 1'b0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         state_q      <= state_d;
         word_cnt_q   <= word_cnt_d;
         wr_hit_q     <= wr_hit_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign word_cnt   = word_cnt_q;
   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: a transaction-level model predicts every output
// each cycle, and per-scenario hand-computed totals pin the model.
module tb_cache_controller;

   localparam int BW = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst, MemRead, MemWrite, Hit, mem_ready;
   logic          Stall, mem_rd_req, mem_wr_req, refill_we, valid_set, cache_wr_en;
   logic [1:0]    word_cnt;
   logic [CW-1:0] hit_count, miss_count;

   int errors = 0;
   int checks = 0;
   bit checking = 0;
   int stall_cycles, wr_req_cycles, wr_en_cycles, refill_cycles, valid_cycles;

   // Model: refill_pos is the next word expected (-1 when no refill is running).
   int refill_pos = -1;
   bit wr_pending = 0;
   bit wr_was_hit = 0;
   bit finishing  = 0;
   int m_hits     = 0;
   int m_misses   = 0;

   always #5 clk = ~clk;

   cache_controller #(.BLOCK_WORDS(BW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .Hit(Hit),
      .mem_ready(mem_ready), .Stall(Stall), .mem_rd_req(mem_rd_req),
      .mem_wr_req(mem_wr_req), .word_cnt(word_cnt), .refill_we(refill_we),
      .valid_set(valid_set), .cache_wr_en(cache_wr_en), .hit_count(hit_count),
      .miss_count(miss_count)
   );

   function automatic int satInc(input int v);
      return (v >= (1 << CW) - 1) ? v : v + 1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, tally observed strobes at mid-cycle, then move past the edge.
   task automatic applyStimulus(input bit r, input bit rd, input bit wr, input bit h, input bit rdy);
      rst = r; MemRead = rd; MemWrite = wr; Hit = h; mem_ready = rdy;
      @(negedge clk);
      if (Stall === 1'b1) stall_cycles++;
      if (mem_wr_req === 1'b1) wr_req_cycles++;
      if (cache_wr_en === 1'b1) wr_en_cycles++;
      if (refill_we === 1'b1) refill_cycles++;
      if (valid_set === 1'b1) valid_cycles++;
      @(posedge clk);
      #1;
   endtask

   task automatic clearTallies();
      stall_cycles = 0; wr_req_cycles = 0; wr_en_cycles = 0; refill_cycles = 0; valid_cycles = 0;
   endtask

   // Model advance on each rising edge, from the transaction rules.
   always @(posedge clk) begin
      if (rst) begin
         refill_pos = -1; wr_pending = 0; wr_was_hit = 0; finishing = 0;
         m_hits = 0; m_misses = 0;
      end else if (refill_pos >= 0) begin
         if (mem_ready) begin
            if (refill_pos == BW - 1) begin
               refill_pos = -1;
               finishing  = 1;
            end else begin
               refill_pos = refill_pos + 1;
            end
         end
      end else if (wr_pending) begin
         if (mem_ready) wr_pending = 0;
      end else if (finishing) begin
         finishing = 0;
      end else if (MemWrite) begin
         wr_pending = 1;
         wr_was_hit = Hit;
         if (Hit) m_hits = satInc(m_hits);
         else m_misses = satInc(m_misses);
      end else if (MemRead) begin
         if (Hit) m_hits = satInc(m_hits);
         else begin
            m_misses   = satInc(m_misses);
            refill_pos = 0;
         end
      end
   end

   // Every-cycle comparison against the model, mid-cycle.
   always @(negedge clk) begin
      if (checking) begin
         bit e_stall, e_rd, e_wr, e_we, e_vs, e_cwe;
         e_stall = 0; e_rd = 0; e_wr = 0; e_we = 0; e_vs = 0; e_cwe = 0;
         if (!rst) begin
            if (refill_pos >= 0) begin
               e_stall = 1; e_rd = 1; e_we = mem_ready;
               e_vs = mem_ready && (refill_pos == BW - 1);
            end else if (wr_pending) begin
               e_wr = 1; e_stall = !mem_ready; e_cwe = mem_ready && wr_was_hit;
            end else if (!finishing) begin
               if (MemWrite) e_stall = 1;
               else if (MemRead) e_stall = !Hit;
            end
         end
         checkOutput("Stall", Stall, e_stall);
         checkOutput("mem_rd_req", mem_rd_req, e_rd);
         checkOutput("mem_wr_req", mem_wr_req, e_wr);
         checkOutput("refill_we", refill_we, e_we);
         checkOutput("valid_set", valid_set, e_vs);
         checkOutput("cache_wr_en", cache_wr_en, e_cwe);
         checkOutput("word_cnt", word_cnt, (refill_pos >= 0) ? refill_pos : 0);
         checkOutput("hit_count", hit_count, m_hits);
         checkOutput("miss_count", miss_count, m_misses);
      end
   end

   initial begin
      clearTallies();
      applyStimulus(1, 0, 0, 0, 0);
      checking = 1;
      applyStimulus(1, 1, 1, 1, 1);
      checkOutput("reset_word_cnt", word_cnt, 0);
      checkOutput("reset_hit_count", hit_count, 0);
      checkOutput("reset_miss_count", miss_count, 0);

      // Three zero-stall read hits, with mem_ready noise that must be ignored.
      clearTallies();
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, i[0]);
      checkOutput("hit3_stalls", stall_cycles, 0);
      checkOutput("hit3_hit_count", hit_count, 3);
      checkOutput("hit3_miss_count", miss_count, 0);

      // Read miss with memory always ready; MemRead held throughout and ignored.
      clearTallies();
      for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("miss_fast_stalls", stall_cycles, 5);
      checkOutput("miss_fast_refills", refill_cycles, 4);
      checkOutput("miss_fast_valid", valid_cycles, 1);
      checkOutput("miss_fast_miss_count", miss_count, 1);

      // Read miss with two wait cycles ahead of every word.
      clearTallies();
      applyStimulus(0, 1, 0, 0, 0);
      for (int w = 0; w < BW; w++) begin
         applyStimulus(0, 1, 0, 0, 0);
         applyStimulus(0, 1, 0, 0, 0);
         applyStimulus(0, 1, 0, 0, 1);
      end
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("miss_slow_stalls", stall_cycles, 13);
      checkOutput("miss_slow_refills", refill_cycles, 4);
      checkOutput("miss_slow_miss_count", miss_count, 2);

      // Store hit, memory ready on the third write-through cycle.
      clearTallies();
      applyStimulus(0, 0, 1, 1, 0);
      applyStimulus(0, 0, 1, 1, 0);
      applyStimulus(0, 0, 1, 1, 0);
      applyStimulus(0, 0, 1, 1, 1);
      checkOutput("store_hit_wr_req", wr_req_cycles, 3);
      checkOutput("store_hit_wr_en", wr_en_cycles, 1);
      checkOutput("store_hit_stalls", stall_cycles, 3);
      checkOutput("store_hit_hit_count", hit_count, 4);

      // Store miss, then a read+write that must act as a store hit.
      clearTallies();
      applyStimulus(0, 0, 1, 0, 1);
      applyStimulus(0, 0, 1, 0, 1);
      checkOutput("store_miss_wr_en", wr_en_cycles, 0);
      checkOutput("store_miss_stalls", stall_cycles, 1);
      checkOutput("store_miss_miss_count", miss_count, 3);
      clearTallies();
      applyStimulus(0, 1, 1, 1, 1);
      applyStimulus(0, 1, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("both_wr_req", wr_req_cycles, 1);
      checkOutput("both_wr_en", wr_en_cycles, 1);
      checkOutput("both_hit_count", hit_count, 5);

      // Reset arriving after word 1 of a refill abandons the line.
      clearTallies();
      applyStimulus(0, 1, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 1);
      applyStimulus(1, 1, 0, 0, 1);
      checkOutput("abort_rd_word_cnt", word_cnt, 0);
      checkOutput("abort_rd_hit_count", hit_count, 0);
      checkOutput("abort_rd_miss_count", miss_count, 0);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("abort_rd_valid", valid_cycles, 0);

      // Reset during a pending write-through drops the write.
      clearTallies();
      applyStimulus(0, 0, 1, 1, 0);
      applyStimulus(0, 0, 1, 1, 0);
      applyStimulus(1, 0, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("abort_wr_wr_en", wr_en_cycles, 0);
      checkOutput("abort_wr_hit_count", hit_count, 0);

      // Hit counter saturation on the 4-bit build.
      for (int i = 0; i < 15; i++) applyStimulus(0, 1, 0, 1, 0);
      checkOutput("sat_hit_count_full", hit_count, 15);
      applyStimulus(0, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("sat_hit_count_held", hit_count, 15);

      checking = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
